// File: rtl/reg_file_param_2r3w.sv
// Parameterised 2-read / 3-write register file with collision and out-of-range reporting.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a read of the same address.
module reg_file_param_2r3w #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 40,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd0_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [WIDTH-1:0]  rd0_data,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [WIDTH-1:0]  rd1_data,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [WIDTH-1:0]  wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [WIDTH-1:0]  wr1_data,
  input  logic              wr2_en,
  input  logic [ADDR_W-1:0] wr2_addr,
  input  logic [WIDTH-1:0]  wr2_data,
  input  logic              cnt_clr,
  output logic              collision,
  output logic              oob_err,
  output logic [7:0]        collision_cnt
);

  logic [2:0]                  w_en, w_ok;
  logic [2:0][ADDR_W-1:0]      w_addr;
  logic [2:0][WIDTH-1:0]       w_data;
  logic [1:0]                  r_en, r_ok;
  logic [1:0][ADDR_W-1:0]      r_addr;
  logic [1:0][WIDTH-1:0]       r_q;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        coll_now, oob_now;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  assign w_en   = {wr2_en, wr1_en, wr0_en};
  assign w_addr = {wr2_addr, wr1_addr, wr0_addr};
  assign w_data = {wr2_data, wr1_data, wr0_data};
  assign r_en   = {rd1_en, rd0_en};
  assign r_addr = {rd1_addr, rd0_addr};

  for (genvar k = 0; k < 3; k++) begin : g_wok
    assign w_ok[k] = w_en[k] && in_range(w_addr[k]);
  end

  // Each entry picks its own winner; wr2 > wr1 > wr0 when several ports hit it.
  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    logic [2:0]       hit;
    logic [WIDTH-1:0] q;
    for (genvar k = 0; k < 3; k++) begin : g_hit
      assign hit[k] = w_ok[k] && (w_addr[k] == ADDR_W'(e));
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         q <= '0;
      else if (hit[2]) q <= w_data[2];
      else if (hit[1]) q <= w_data[1];
      else if (hit[0]) q <= w_data[0];
    end
    assign mem[e] = q;
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [WIDTH-1:0] rv, q;
    assign r_ok[p] = in_range(r_addr[p]);
    // Out-of-range addresses match no entry and fall through to zero.
    always_comb begin
      rv = '0;
      for (int e = 0; e < DEPTH; e++)
        if (r_addr[p] == ADDR_W'(e)) rv = mem[e];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < 3; k++)
        if (w_ok[k] && (w_addr[k] == r_addr[p])) rv = w_data[k];
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst)           q <= '0;
      else if (r_en[p])  q <= rv;
    end
    assign r_q[p] = q;
  end

  assign rd0_data = r_q[0];
  assign rd1_data = r_q[1];

  // Any colliding pair counts once, even if all three ports share an address.
  assign coll_now = (w_ok[0] && w_ok[1] && (w_addr[0] == w_addr[1])) ||
                    (w_ok[0] && w_ok[2] && (w_addr[0] == w_addr[2])) ||
                    (w_ok[1] && w_ok[2] && (w_addr[1] == w_addr[2]));
  assign oob_now  = |(w_en & ~w_ok) || (rd0_en && !r_ok[0]) || (rd1_en && !r_ok[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collision     <= 1'b0;
      oob_err       <= 1'b0;
      collision_cnt <= '0;
    end else begin
      collision <= coll_now;
      oob_err   <= oob_now;
      if (cnt_clr)                                 collision_cnt <= '0;
      else if (coll_now && collision_cnt != 8'hFF) collision_cnt <= collision_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_reg_file_param_2r3w.sv
// Bench for reg_file_param_2r3w: vector table plus multi-cycle saturation and async-reset sequences.
module tb_reg_file_param_2r3w;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        rd0_en = 0, rd1_en = 0, wr0_en = 0, wr1_en = 0, wr2_en = 0, cnt_clr = 0;
  logic [5:0]  rd0_addr = 0, rd1_addr = 0, wr0_addr = 0, wr1_addr = 0, wr2_addr = 0;
  logic [63:0] wr0_data = 0, wr1_data = 0, wr2_data = 0, rd0_data, rd1_data;
  logic        collision, oob_err;
  logic [7:0]  collision_cnt;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [2:0]  we;
    logic [5:0]  wa0, wa1, wa2;
    logic [63:0] wd0, wd1, wd2;
    logic        r0e;
    logic [5:0]  ra0;
    logic        r1e;
    logic [5:0]  ra1;
    logic        clr;
    logic        chk;
    logic [63:0] e0, e1;
    logic        ec, eo;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t tbl[19];
  vec_t sb[$];

  reg_file_param_2r3w dut (
    .clk(clk), .rst(rst),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .wr2_en(wr2_en), .wr2_addr(wr2_addr), .wr2_data(wr2_data),
    .cnt_clr(cnt_clr), .collision(collision), .oob_err(oob_err),
    .collision_cnt(collision_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input longint we, wa0, wa1, wa2, wd0, wd1, wd2,
                              r0e, ra0, r1e, ra1, clr, chk, e0, e1, ec, eo, ecnt);
    vec_t v;
    v.we = 3'(we); v.wa0 = 6'(wa0); v.wa1 = 6'(wa1); v.wa2 = 6'(wa2);
    v.wd0 = 64'(wd0); v.wd1 = 64'(wd1); v.wd2 = 64'(wd2);
    v.r0e = 1'(r0e); v.ra0 = 6'(ra0); v.r1e = 1'(r1e); v.ra1 = 6'(ra1);
    v.clr = 1'(clr); v.chk = 1'(chk); v.e0 = 64'(e0); v.e1 = 64'(e1);
    v.ec = 1'(ec); v.eo = 1'(eo); v.ecnt = 8'(ecnt);
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic apply(input vec_t v, input string nm);
    vec_t e;
    {wr2_en, wr1_en, wr0_en} = v.we;
    wr0_addr = v.wa0; wr1_addr = v.wa1; wr2_addr = v.wa2;
    wr0_data = v.wd0; wr1_data = v.wd1; wr2_data = v.wd2;
    rd0_en = v.r0e; rd0_addr = v.ra0; rd1_en = v.r1e; rd1_addr = v.ra1;
    cnt_clr = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: scoreboard empty got 0 expected 1", nm);
      return;
    end
    e = sb.pop_front();
    if (e.chk) begin
      check({nm, ".rd0"}, rd0_data, e.e0);
      check({nm, ".rd1"}, rd1_data, e.e1);
    end
    check({nm, ".coll"}, 64'(collision), 64'(e.ec));
    check({nm, ".oob"},  64'(oob_err),   64'(e.eo));
    check({nm, ".cnt"},  64'(collision_cnt), 64'(e.ecnt));
  endtask

  initial begin
    logic [63:0] d, b14, b16;
    d   = 64'hDEAD_BEEF_0123_4567;
    b14 = BYP ? 64'h88 : 64'h77;
    b16 = BYP ? d : 64'h0;
    //            we wa0 wa1 wa2 wd0   wd1    wd2   r0e ra0 r1e ra1 clr chk e0 e1 ec eo cnt
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,          1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(5, 3, 0, 3, 'hA, 0, 'hC,      0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0,          1, 3, 0, 0, 0, 1, 'hC, 0, 0, 0, 1);
    tbl[3]  = mk(2, 0, 7, 0, 0, 'h55, 0,       1, 7, 0, 0, 0, 1, BYP ? 'h55 : 0, 0, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,          1, 7, 1, 7, 0, 1, 'h55, 'h55, 0, 0, 1);
    tbl[5]  = mk(1, 40, 0, 0, 'hFF, 0, 0,      0, 0, 0, 0, 0, 1, 'h55, 'h55, 0, 1, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,          0, 0, 1, 45, 0, 1, 'h55, 0, 0, 1, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0,          1, 8, 1, 39, 0, 1, 0, 0, 0, 0, 1);
    tbl[8]  = mk(7, 1, 1, 2, 'h11, 'h22, 'h33, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,          1, 1, 1, 2, 0, 1, 'h22, 'h33, 0, 0, 2);
    tbl[10] = mk(7, 4, 4, 4, 1, 2, 3,          0, 0, 0, 0, 0, 1, 'h22, 'h33, 1, 0, 3);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0,          1, 4, 0, 0, 0, 1, 3, 'h33, 0, 0, 3);
    tbl[12] = mk(3, 50, 50, 0, 1, 2, 0,        0, 0, 0, 0, 0, 1, 3, 'h33, 0, 1, 3);
    tbl[13] = mk(5, 6, 0, 6, 'h66, 0, 'h77,    0, 0, 0, 0, 1, 1, 3, 'h33, 1, 0, 0);
    tbl[14] = mk(4, 0, 0, 6, 0, 0, 'h88,       1, 6, 1, 6, 0, 1, b14, b14, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0,          0, 60, 1, 6, 0, 1, b14, 'h88, 0, 0, 0);
    tbl[16] = mk(4, 0, 0, 39, 0, 0, d,         0, 0, 1, 39, 0, 1, b14, b16, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0,          1, 39, 0, 0, 0, 1, d, b16, 0, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, -1, 0,         1, 0, 0, 0, 0, 1, 0, b16, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset.rd0", rd0_data, 0);
    check("reset.rd1", rd1_data, 0);
    check("reset.coll", 64'(collision), 0);
    check("reset.oob", 64'(oob_err), 0);
    check("reset.cnt", 64'(collision_cnt), 0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Saturation: 300 back-to-back collisions, then clear racing a collision.
    for (int i = 0; i < 300; i++)
      apply(mk(3, 20, 20, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, (i + 1 > 255) ? 255 : i + 1),
            $sformatf("sat%0d", i));
    apply(mk(3, 20, 20, 0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), "sat_clr");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sat_idle");

    // Fill, read back, then hit async reset mid-sequence.
    apply(mk(5, 0, 0, 0, 9, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), "pre_coll");
    for (int i = 0; i < 20; i++)
      apply(mk(1, i, 0, 0, i + 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), $sformatf("fill%0d", i));
    for (int k = 0; k < 10; k++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 2 * k, 1, 2 * k + 1, 0, 1, 2 * k + 1, 2 * k + 2, 0, 0, 1),
            $sformatf("rdback%0d", k));
    for (int i = 20; i < 30; i++)
      apply(mk(1, i, 0, 0, i + 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), $sformatf("fill%0d", i));
    wr0_en = 1; wr0_addr = 30; wr0_data = 31; rd0_en = 1; rd0_addr = 5;
    #2 rst = 1'b1;
    #1;
    check("async.rd0", rd0_data, 0);
    check("async.rd1", rd1_data, 0);
    check("async.coll", 64'(collision), 0);
    check("async.cnt", 64'(collision_cnt), 0);
    sb.delete();
    @(posedge clk);
    #1;
    check("async.hold_rd0", rd0_data, 0);
    {wr2_en, wr1_en, wr0_en} = 3'b000; rd0_en = 0; rd1_en = 0;
    rst = 1'b0;
    for (int k = 0; k < 20; k++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 2 * k, 1, 2 * k + 1, 0, 1, 0, 0, 0, 0, 0),
            $sformatf("postrst%0d", k));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
